// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// ball_engine : 2x2 ball stepper; erases/redraws through an arbitrated pixel port
// Optional macro BALL_SPEEDUP_EN : tick period halves per level (every 4th hit)
// Rev 1.0
// ============================================================================
module ball_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PADDLE_W = 16,
    parameter int TICK_DIV = 833333,
    parameter int START_X  = 80,
    parameter int START_Y  = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] paddle_x,
    input  logic [6:0] paddle_y,
    input  logic       vga_grant,
    output logic       vga_req,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       miss
);
    localparam int         CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [8:0] C_X_MAX    = 9'(SCREEN_W - 2);
    localparam logic [8:0] C_Y_MAX    = 9'(SCREEN_H - 2);
    localparam logic [8:0] C_PAD_SPAN = 9'(PADDLE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ERASE = 3'd2,
        S_MOVE  = 3'd3,
        S_DRAW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_tick;
    logic [1:0]       r_idx;
    logic [7:0]       r_ball_x;
    logic [6:0]       r_ball_y;
    logic             r_dx_neg, r_dy_neg;
    logic [8:0]       w_nx, w_ny;
    logic             w_wall, w_top, w_bottom, w_paddle, w_move, w_sweep;

`ifdef BALL_SPEEDUP_EN
    logic [1:0] r_level;
    logic [1:0] r_hits;
    assign w_period_m1 = CNT_W'((TICK_DIV >> r_level) - 1);
`else
    assign w_period_m1 = CNT_W'(TICK_DIV - 1);
`endif

    // >= keeps the counter bounded if the period shrinks past the current count
    assign w_tick = (r_cnt >= w_period_m1);

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_cnt <= '0;
        else                 r_cnt <= r_cnt + 1'b1;
    end

    // Candidate position; bit 8 set means the step went below zero
    assign w_nx     = {1'b0, r_ball_x} + (r_dx_neg ? 9'h1FF : 9'h001);
    assign w_ny     = {2'b00, r_ball_y} + (r_dy_neg ? 9'h1FF : 9'h001);
    assign w_wall   = w_nx[8] || (w_nx > C_X_MAX);
    assign w_top    = w_ny[8];
    assign w_bottom = !w_ny[8] && (w_ny > C_Y_MAX);
    assign w_paddle = !r_dy_neg
                   && ({2'b00, r_ball_y} + 9'd2 == {2'b00, paddle_y})
                   && ({1'b0, r_ball_x} + 9'd1 >= {1'b0, paddle_x})
                   && ({1'b0, r_ball_x} <= {1'b0, paddle_x} + C_PAD_SPAN);
    assign w_move   = (r_state == S_MOVE);
    assign miss     = w_move && w_bottom && !w_paddle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ball_x <= 8'(START_X);
            r_ball_y <= 7'(START_Y);
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
        end else if (miss) begin
            r_ball_x <= 8'(START_X);
            r_ball_y <= 7'(START_Y);
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b1;
        end else if (w_move) begin
            if (w_wall) r_dx_neg <= !r_dx_neg;
            else        r_ball_x <= w_nx[7:0];
            if (w_top || w_paddle) r_dy_neg <= !r_dy_neg;
            else                   r_ball_y <= w_ny[6:0];
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (reset || miss) begin
            r_level <= 2'd0;
            r_hits  <= 2'd0;
        end else if (w_move && w_paddle) begin
            r_hits <= r_hits + 2'd1;
            if (r_hits == 2'd3 && r_level != 2'd2) r_level <= r_level + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pixel index advances only on cycles where the arbiter accepted the pixel
    always_ff @(posedge clk) begin
        if (reset || !w_sweep)  r_idx <= 2'd0;
        else if (vga_grant)     r_idx <= r_idx + 2'd1;
    end

    assign w_sweep = (r_state == S_ERASE) || (r_state == S_DRAW);

    always_comb begin
        w_state_nxt = r_state;
        vga_req     = 1'b0;
        plot        = 1'b0;
        x_out       = 8'd0;
        y_out       = 7'd0;
        colour_out  = 3'b000;
        case (r_state)
            S_IDLE:  if (w_tick && enable) w_state_nxt = S_REQ;
            S_REQ: begin
                vga_req = 1'b1;
                if (vga_grant) w_state_nxt = S_ERASE;
            end
            S_ERASE, S_DRAW: begin
                vga_req    = 1'b1;
                plot       = vga_grant;
                x_out      = r_ball_x + {7'd0, r_idx[0]};
                y_out      = r_ball_y + {6'd0, r_idx[1]};
                colour_out = (r_state == S_DRAW) ? 3'b111 : 3'b000;
                if (vga_grant && r_idx == 2'd3)
                    w_state_nxt = (r_state == S_DRAW) ? S_DONE : S_MOVE;
            end
            S_MOVE: begin
                vga_req     = 1'b1;
                w_state_nxt = S_DRAW;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ball_x = r_ball_x;
    assign ball_y = r_ball_y;

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ball_engine : directed scoreboard bench for ball_engine (TICK_DIV = 20)
// Rev 1.0
// ============================================================================
module tb_ball_engine;
    localparam int TICK = 20;

    logic       clk = 1'b0;
    logic       reset, enable, vga_grant;
    logic [7:0] paddle_x;
    logic [6:0] paddle_y;
    logic       vga_req, plot, miss;
    logic [7:0] x_out, ball_x;
    logic [6:0] y_out, ball_y;
    logic [2:0] colour_out;

    ball_engine #(.TICK_DIV(TICK)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .paddle_x   (paddle_x),
        .paddle_y   (paddle_y),
        .vga_grant  (vga_grant),
        .vga_req    (vga_req),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .miss       (miss)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [17:0] exp_q[$];
    int          frame_plots = 0;
    int          miss_cycles = 0;
    int          miss_base = 0;
    longint      t_rise = 0;
    longint      t_prev = 0;
    int          mx, my, mdx, mdy;
    bit          m_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pixel scoreboard and miss-pulse width, sampled mid-cycle
    always @(negedge clk) begin
        logic [17:0] e;
        if (miss === 1'b1) miss_cycles++;
        if (vga_grant === 1'b0 && reset === 1'b0) chk("plot_gated_by_grant", 32'(plot), 32'd0);
        if (plot === 1'b1 && vga_grant === 1'b1) begin
            frame_plots++;
            if (exp_q.size() == 0) begin
                chk("pixel_expected_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pixel_xyc", 32'({x_out, y_out, colour_out}), 32'(e));
            end
        end
    end

    // Reference ball: push this frame's erase/draw pixels, then advance
    task automatic model_frame();
        int nx, ny;
        bit wall, top, pad, bot;
        for (int i = 0; i < 4; i++)
            exp_q.push_back({8'(mx + (i % 2)), 7'(my + (i / 2)), 3'b000});
        nx   = mx + mdx;
        ny   = my + mdy;
        wall = (nx < 0) || (nx > 158);
        top  = (ny < 0);
        pad  = (mdy == 1) && (my + 2 == int'(paddle_y)) &&
               (mx + 1 >= int'(paddle_x)) && (mx <= int'(paddle_x) + 15);
        bot  = (ny > 118);
        m_miss = bot && !pad;
        if (m_miss) begin
            mx = 80; my = 40; mdx = 1; mdy = -1;
        end else begin
            if (wall) mdx = -mdx; else mx = nx;
            if (top || pad) mdy = -mdy; else my = ny;
        end
        for (int i = 0; i < 4; i++)
            exp_q.push_back({8'(mx + (i % 2)), 7'(my + (i / 2)), 3'b111});
        frame_plots = 0;
        miss_base   = miss_cycles;
    endtask

    task automatic wait_rise();
        bit got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (vga_req === 1'b1) begin got = 1; break; end
        end
        chk("req_rise_seen", 32'(got), 32'd1);
        t_prev = t_rise;
        t_rise = longint'($time);
    endtask

    task automatic finish_frame(input int exp_len);
        bit got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (vga_req === 1'b0) begin got = 1; break; end
        end
        chk("req_fall_seen", 32'(got), 32'd1);
        chk("req_high_cycles", 32'((longint'($time) - t_rise) / 10), 32'(exp_len));
        chk("pixels_left", 32'(exp_q.size()), 32'd0);
        chk("frame_plots", 32'(frame_plots), 32'd8);
        chk("ball_x", 32'(ball_x), 32'(mx));
        chk("ball_y", 32'(ball_y), 32'(my));
        chk("miss_pulse_cycles", 32'(miss_cycles - miss_base), 32'(m_miss));
        exp_q.delete();
        step();
    endtask

    task automatic run_frame();
        model_frame();
        wait_rise();
        finish_frame(10);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; enable = 1'b1; vga_grant = 1'b1; paddle_x = 8'd0; paddle_y = 7'd100;
        mx = 80; my = 40; mdx = 1; mdy = 1;
        step(); step(); step();
        @(negedge clk);
        chk("rst_vga_req", 32'(vga_req), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_colour", 32'(colour_out), 32'd0);
        chk("rst_ball_x", 32'(ball_x), 32'd80);
        chk("rst_ball_y", 32'(ball_y), 32'd40);

        // First frame: tick on the 20th cycle after reset, REQ the cycle after
        model_frame();
        step();
        reset = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vga_req === 1'b1) begin lat = k; break; end
        end
        chk("first_req_cycle", 32'(lat), 32'd20);
        t_rise = longint'($time);
        finish_frame(10);

        model_frame();
        wait_rise();
        chk("tick_spacing", 32'((t_rise - t_prev) / 10), 32'(TICK));
        finish_frame(10);

        // Paddle hit with the ball's left edge at the paddle's last column
        for (int f = 0; f < 200 && !(my == 98 && mdy == 1); f++) run_frame();
        chk("reach_y98_a", 32'(ball_y), 32'd98);
        paddle_x = 8'(mx - 15);
        run_frame();
        chk("paddle_hit_y_hold", 32'(ball_y), 32'd98);
        paddle_x = 8'd0;

        // Right wall: x holds at 158 then steps back to 157
        for (int f = 0; f < 100 && !(mx == 158 && mdx == 1); f++) run_frame();
        chk("reach_x158", 32'(ball_x), 32'd158);
        run_frame();
        chk("wall_x_hold", 32'(ball_x), 32'd158);
        run_frame();
        chk("wall_rebound_x", 32'(ball_x), 32'd157);

        // Disable mid-frame: frame completes, then no further requests
        model_frame();
        wait_rise();
        enable = 1'b0;
        finish_frame(10);
        lat = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (vga_req === 1'b1) lat++;
        end
        chk("disabled_req_cycles", 32'(lat), 32'd0);
        step();
        enable = 1'b1;

        // Paddle one column right of the ball: no hit
        for (int f = 0; f < 400 && !(my == 98 && mdy == 1); f++) run_frame();
        chk("reach_y98_b", 32'(ball_y), 32'd98);
        paddle_x = 8'(mx + 2);
        run_frame();
        chk("paddle_edge_miss_y", 32'(ball_y), 32'd99);
        paddle_x = 8'd0;

        // Bottom exit
        for (int f = 0; f < 40 && !(my == 118 && mdy == 1); f++) run_frame();
        chk("reach_y118", 32'(ball_y), 32'd118);
        run_frame();
        chk("miss_one_cycle", 32'(miss_cycles - miss_base), 32'd1);
        chk("miss_restart_x", 32'(ball_x), 32'd80);
        chk("miss_restart_y", 32'(ball_y), 32'd40);
        run_frame();
        chk("post_miss_y_up", 32'(ball_y), 32'd39);
        chk("post_miss_x", 32'(ball_x), 32'd81);

        // Grant withheld 5 cycles in REQ and dropped 3 cycles mid-ERASE
        vga_grant = 1'b0;
        model_frame();
        wait_rise();
        repeat (5) step();
        vga_grant = 1'b1;
        repeat (3) step();
        vga_grant = 1'b0;
        repeat (3) step();
        vga_grant = 1'b1;
        finish_frame(18);

        // Reset during the second DRAW pixel
        model_frame();
        wait_rise();
        repeat (7) step();
        reset = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("abort_plots_done", 32'(frame_plots), 32'd6);
        chk("abort_vga_req", 32'(vga_req), 32'd0);
        chk("abort_plot", 32'(plot), 32'd0);
        chk("abort_ball_x", 32'(ball_x), 32'd80);
        chk("abort_ball_y", 32'(ball_y), 32'd40);
        exp_q.delete();
        mx = 80; my = 40; mdx = 1; mdy = 1;
        step();
        reset = 1'b0;
        run_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Ball stage for the 160x120 paddle game. Sits beside and downstream of the paddle stage.
- Consumes the paddle position from the paddle stage's x/y counter.
- Steps a 2x2 ball once per frame tick, and bounces it off the side walls, the top wall and the paddle.
- Erases and redraws the ball through the shared VGA pixel port using a req/grant handshake with the pixel arbiter in front of vga_adapter.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- PADDLE_W, 16, paddle width; the paddle occupies paddle_x .. paddle_x+15.
- TICK_DIV, 833333, clk cycles per move tick (60 Hz at 50 MHz).
- START_X, 80, ball x after reset or a miss.
- START_Y, 40, ball y after reset or a miss.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high.
- enable  in  1  game running; 0 freezes the ball.
- paddle_x  in  8  paddle left x.
- paddle_y  in  7  paddle row.
- vga_grant  in  1  arbiter grants the pixel port.
- vga_req  out  1  pixel port request.
- x_out  out  8  pixel x to arbiter.
- y_out  out  7  pixel y to arbiter.
- colour_out  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- ball_x  out  8  current ball top-left x.
- ball_y  out  7  current ball top-left y.
- miss  out  1  one-cycle pulse when the ball leaves via the bottom.

Behaviour:
- Reset, sampled on clk rising edge while reset=1:
  - ball_x=START_X, ball_y=START_Y, dx=+1, dy=+1.
  - vga_req=0, plot=0, miss=0, x_out=0, y_out=0, colour_out=000.
  - Tick counter=0, FSM=IDLE.
- Reset mid-operation aborts any erase/draw immediately. A partially drawn ball may be left on screen; this is acceptable.
- Tick counter: free-running 0..TICK_DIV-1. tick=1 for one cycle when the counter equals TICK_DIV-1.
- A tick arriving while the FSM is not in IDLE, or while enable=0, is dropped (never queued).
- FSM states:
  - IDLE: on tick && enable -> REQ.
  - REQ: vga_req=1; on vga_grant -> ERASE.
  - ERASE: plots 4 pixels of colour 000 at (ball_x+i[0], ball_y+i[1]) for i=0..3, one per cycle, plot=1. After i=3 -> MOVE.
  - MOVE: one cycle, plot=0; position/direction update -> DRAW.
  - DRAW: same 4-pixel sweep with colour 111 at the new position -> DONE.
  - DONE: vga_req=0 for one cycle -> IDLE.
- vga_req stays high from REQ through DRAW.
- If vga_grant drops during ERASE or DRAW: plot=0 and the pixel index holds; resume when grant returns. A pixel is counted only on a cycle where plot && vga_grant.
- Latency, grant held: tick to first plot = 2 cycles. Whole frame = 12 cycles from tick to IDLE.
- Move arithmetic: 9-bit signed intermediates nx = ball_x+dx, ny = ball_y+dy.
  - Left/right wall: if nx<0 or nx>SCREEN_W-2, negate dx; x unchanged this move.
  - Top: if ny<0, negate dy; y unchanged.
  - Paddle hit: dy=+1 && ball_y+2==paddle_y && ball_x+1>=paddle_x && ball_x<=paddle_x+PADDLE_W-1. Negate dy; y unchanged.
  - Corner: wall and top/paddle in the same move flip both dx and dy; position unchanged.
  - Bottom: ny>SCREEN_H-2 gives miss=1 for that cycle, ball reset to START_X/START_Y, dx=+1, dy=-1.
  - Otherwise ball_x<=nx, ball_y<=ny.
- ball_x/ball_y change only in MOVE.
- Deasserting enable mid-frame lets the current frame finish; the ball then stays in IDLE.

Optional Feature:
- Macro BALL_SPEEDUP_EN.
- Defined:
  - A 2-bit level (0..2) increments on every 4th paddle hit, saturating at 2.
  - Effective tick period = TICK_DIV >> level.
  - Level and hit count clear on reset and on miss.
- Undefined: period fixed at TICK_DIV; no level or hit-count logic.

Test Plan (all scenarios use TICK_DIV=20):
- Reset, then tie vga_grant=1, enable=1, first tick -> plots (80,40),(81,40),(80,41),(81,41) in 000, then (81,41),(82,41),(81,42),(82,42) in 111; vga_req low at DONE.
- Ball at x=158 with dx=+1 -> next move keeps x=158 with dx=-1; following move gives x=157.
- Paddle_x=70, paddle_y=100, ball (75,98) moving down -> dy flips, y stays 98. Same setup with paddle_x=90 -> y=99.
- Ball at y=118 moving down -> miss pulse exactly 1 cycle; ball_x/ball_y become 80/40; dy=-1.
- vga_grant held low 5 cycles after req, then dropped for 3 cycles mid-ERASE -> exactly 8 plot strobes total; no pixel skipped or duplicated.
- reset asserted during DRAW -> next cycle vga_req=0, plot=0, ball=(80,40). With BALL_SPEEDUP_EN, 4 paddle hits -> tick spacing becomes 10 cycles.
